// File: rtl/conv_ofm_reader_if.sv
// Output element stream of the conv OFM reader.
// Handshake: an element moves on a rising clock edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// producer holds out_data/out_row/out_col/out_last/out_sat unchanged, and
// out_valid never drops before the element has moved.
interface conv_ofm_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]      out_row;
    logic [IDX_W-1:0]      out_col;
    logic                  out_last;
    logic                  out_sat;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last, out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last, out_sat,
        output out_ready
    );
endinterface

// File: rtl/conv_ofm_reader.sv
// Streams a finished conv output map in raster order, requantizing each
// signed accumulator (optional ReLU, arithmetic right shift, saturation)
// down to DATA_WIDTH bits. The map is read in place from the flattened ofm
// bus, which upstream holds stable while busy is high.
module conv_ofm_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_WIDTH  = 26,
    parameter int MAP_SIZE   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [BUF_WIDTH*MAP_SIZE*MAP_SIZE-1:0] ofm,
    input  logic                                 finish,
    input  logic [4:0]                           shift,
    input  logic                                 relu_en,
    conv_ofm_reader_if.master                    out_if,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun
);

    localparam int IDX_W     = $clog2(MAP_SIZE);
    localparam int NUM       = MAP_SIZE * MAP_SIZE;
    localparam int NUM_W     = $clog2(NUM);
    localparam int OFM_W     = BUF_WIDTH * NUM;
    localparam int OFM_IDX_W = $clog2(OFM_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAP_SIZE - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]     row_q, col_q;
    logic [4:0]           shift_q;
    logic                 relu_q;
    logic                 done_q;
    logic                 overrun_q;

    logic                 accept;
    logic                 xfer;
    logic                 at_last;
    logic                 streaming;

    logic [NUM_W-1:0]     elem_idx;
    logic [OFM_IDX_W-1:0] elem_base;
    logic signed [BUF_WIDTH-1:0] elem;
    logic signed [BUF_WIDTH-1:0] relu_v;
    logic signed [BUF_WIDTH-1:0] shifted;
    logic                 fits;
    logic [DATA_WIDTH-1:0] q_data;
    logic                 q_sat;

    assign streaming = (state_q == S_STREAM);
    assign accept    = (state_q == S_IDLE) && finish;
    assign xfer      = streaming && out_if.out_ready;
    assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on finish from idle, return after the last element moves
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (finish)          state_d = S_STREAM;
            S_STREAM: if (xfer && at_last) state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Outputs: everything on the stream is zero outside STREAM
    always_comb begin
        out_if.out_valid = streaming;
        out_if.out_row   = streaming ? row_q : '0;
        out_if.out_col   = streaming ? col_q : '0;
        out_if.out_last  = streaming && at_last;
        out_if.out_data  = streaming ? q_data : '0;
        out_if.out_sat   = streaming && q_sat;
        busy             = streaming;
    end

    // Frame settings are captured once, when the frame is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (accept) begin
            shift_q <= shift;
            relu_q  <= relu_en;
        end
    end

    // Raster position: column first, row advances on column wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            row_q <= '0;
            col_q <= '0;
        end else if (xfer) begin
            if (col_q == LAST_IDX) begin
                col_q <= '0;
                row_q <= (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Completion pulse and sticky overrun flag (finish seen while streaming)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= xfer && at_last;
            overrun_q <= overrun_q | (streaming && finish);
        end
    end

    assign done    = done_q;
    assign overrun = overrun_q;

    // Element fetch and requantization: relu, arithmetic shift, clip to DATA_WIDTH
    always_comb begin
        elem_idx  = NUM_W'(row_q) * NUM_W'(MAP_SIZE) + NUM_W'(col_q);
        elem_base = OFM_IDX_W'(elem_idx) * OFM_IDX_W'(BUF_WIDTH);
        elem      = ofm[elem_base +: BUF_WIDTH];
        relu_v    = (relu_q && elem[BUF_WIDTH-1]) ? '0 : elem;
        shifted   = relu_v >>> shift_q;
        // In range when all bits from the output sign bit upward agree
        fits      = (&shifted[BUF_WIDTH-1:DATA_WIDTH-1]) || (~|shifted[BUF_WIDTH-1:DATA_WIDTH-1]);
        q_sat     = !fits;
        if (fits) begin
            q_data = shifted[DATA_WIDTH-1:0];
        end else if (shifted[BUF_WIDTH-1]) begin
            q_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            q_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

endmodule
